// File: rtl/key_display.sv
// key_display: decodes keypad row/column pairs into a two-digit hex history and drives a multiplexed seven-segment display
//   clk, reset             : clock and synchronous active-high reset
//   new_key/row_pwr/cols_key: scanner pulse plus one-hot row and column
//   seg, an                : active-low segments {g..a} and digit enables (an[0] = right/recent)
//   digit_recent/digit_old : latest and previous accepted key codes
//   key_err                : one-cycle pulse when a key event is rejected
module key_display #(
  parameter logic [23:0] MUX_DIV = 24'd48000,
  parameter logic [23:0] BLANK = 24'd16,
  parameter int unsigned CNT_W = 24
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       new_key,
  input  logic [3:0] row_pwr,
  input  logic [3:0] cols_key,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic [3:0] digit_recent,
  output logic [3:0] digit_old,
  output logic       key_err
);
  // nibble at {row,col} holds the key code; row 0 / col 0 in the low nibble
  localparam logic [63:0] KEYMAP = 64'hDF0E_C987_B654_A321;
  // 7-bit active-low pattern per hex digit, digit 0 in the low bits
  localparam logic [111:0] HEX7 = {
    7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110,
    7'b0000011, 7'b0001000, 7'b0010000, 7'b0000000,
    7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001,
    7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
  };
  logic [CNT_W-1:0] r_cnt;
  logic             r_phase;
  logic [1:0]       w_row;
  logic [1:0]       w_col;
  logic             w_valid;
  logic             w_wrap;
  logic [3:0]       w_code;
  logic [3:0]       w_shown;
  // one-hot to index encoding; only meaningful when w_valid
  assign w_row   = {row_pwr[3] | row_pwr[2], row_pwr[3] | row_pwr[1]};
  assign w_col   = {cols_key[3] | cols_key[2], cols_key[3] | cols_key[1]};
  assign w_valid = $onehot(row_pwr) && $onehot(cols_key);
  assign w_code  = KEYMAP[{w_row, w_col, 2'b00} +: 4];
  assign w_wrap  = r_cnt == CNT_W'(MUX_DIV - 24'd1);
  assign w_shown = r_phase ? digit_old : digit_recent;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt        <= '0;
      r_phase      <= 1'b0;
      digit_recent <= 4'h0;
      digit_old    <= 4'h0;
      key_err      <= 1'b0;
      an           <= 2'b11;
      seg          <= 7'b1000000;
    end else begin
      r_cnt   <= w_wrap ? '0 : r_cnt + 1'b1;
      r_phase <= r_phase ^ w_wrap;
      key_err <= new_key & ~w_valid;
      if (new_key && w_valid) begin
        digit_old    <= digit_recent;
        digit_recent <= w_code;
      end
      // both enables off for the first BLANK clocks of a phase to hide ghosting
      an  <= (r_cnt < CNT_W'(BLANK)) ? 2'b11 : (r_phase ? 2'b01 : 2'b10);
      seg <= HEX7[7*w_shown +: 7];
    end
  end
endmodule
